pipe_seq_checker: RTL and testbench

- Self-checking traffic endpoint for fixed-latency pipelines such as the 2-stage `Pipe`.
- Drives an incrementing stimulus into the pipeline input and receives the pipeline output.
- Compares the received output against an internally delayed copy of the stimulus.
- Reports pass/fail, error count and the index of the first mismatch. Used as the tester/receiver end around delay-line DUTs in regression tops.

---
 rtl/pipe_chk_pkg.sv | 19 +
 rtl/pipe_chk_delay.sv | 37 +++
 rtl/pipe_seq_checker.sv | 112 +++++++++++
 tb/tb_pipe_seq_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_chk_pkg.sv
// Shared types and helpers for the pipeline sequence checker.
package pipe_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  localparam int         ERR_CNT_W  = 8;
  localparam logic [7:0] NO_ERR_IDX = 8'hFF;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc8(input logic [ERR_CNT_W-1:0] value);
    return (value == {ERR_CNT_W{1'b1}}) ? value : value + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_chk_delay.sv
// Reference delay line: reproduces the expected DUT latency on the stimulus.
// Cleared synchronously at run start so stale samples never reach the comparator.
module pipe_chk_delay #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (LATENCY == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clock, reset, clear};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] taps [LATENCY];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LATENCY; i++) taps[i] <= '0;
        end else if (clear) begin
          for (int i = 0; i < LATENCY; i++) taps[i] <= '0;
        end else begin
          taps[0] <= din;
          for (int i = 1; i < LATENCY; i++) taps[i] <= taps[i-1];
        end
      end

      assign dout = taps[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/pipe_seq_checker.sv
// Traffic endpoint driving a counting stimulus into a fixed-latency pipeline and checking its output.
// Define PIPE_CHK_STOP_ON_FAIL_EN to end a run on the cycle after the first mismatch.
module pipe_seq_checker
  import pipe_chk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LATENCY   = 2,
  parameter int CHECK_LEN = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic [WIDTH-1:0]     stim_out,
  input  logic [WIDTH-1:0]     resp_in,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           first_err_idx
);

  localparam logic [3:0] LAST_WARM   = 4'((LATENCY == 0) ? 0 : LATENCY - 1);
  localparam logic [7:0] LAST_SAMPLE = 8'(CHECK_LEN - 1);

  chk_state_t       state, next_state;
  logic [3:0]       cyc_cnt;
  logic [7:0]       smp_cnt;
  logic [WIDTH-1:0] expected;
  logic             run_start;
  logic             mismatch;
  logic             next_busy;

  assign run_start = start && ((state == IDLE) || (state == DONE));
  assign mismatch  = (state == CHECK) && (resp_in != expected);
  assign next_busy = (next_state == WARM) || (next_state == CHECK);
  assign busy      = (state == WARM) || (state == CHECK);
  assign done      = (state == DONE);

  pipe_chk_delay #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .clear (run_start),
    .din   (stim_out),
    .dout  (expected)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = (LATENCY == 0) ? CHECK : WARM;
      end
      WARM: begin
        if (cyc_cnt == LAST_WARM) next_state = CHECK;
      end
      CHECK: begin
`ifdef PIPE_CHK_STOP_ON_FAIL_EN
        if (mismatch || (smp_cnt == LAST_SAMPLE)) next_state = DONE;
`else
        if (smp_cnt == LAST_SAMPLE) next_state = DONE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // Stimulus restarts at zero for every run and idles at zero outside a run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stim_out <= '0;
      cyc_cnt  <= '0;
      smp_cnt  <= '0;
    end else begin
      if (run_start || !next_busy) stim_out <= '0;
      else                         stim_out <= stim_out + WIDTH'(1);

      if (run_start)           cyc_cnt <= '0;
      else if (state == WARM)  cyc_cnt <= cyc_cnt + 4'd1;

      if (run_start)           smp_cnt <= '0;
      else if (state == CHECK) smp_cnt <= smp_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fail          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= NO_ERR_IDX;
    end else if (run_start) begin
      fail          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= NO_ERR_IDX;
    end else if (mismatch) begin
      fail      <= 1'b1;
      err_count <= sat_inc8(err_count);
      if (first_err_idx == NO_ERR_IDX) first_err_idx <= smp_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_seq_checker.sv
// Directed bench for pipe_seq_checker: clean, corrupted, wrong-latency, wrap, restart and reset runs.
module tb_pipe_seq_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       start20;
  logic [3:0] stim_out, resp_in, stim20, resp20;
  logic       busy, done, fail, busy20, done20, fail20;
  logic [7:0] err_count, first_err_idx, err20, idx20;
  int         mode;
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [3:0] d1, d2, d1_20, d2_20;

`ifdef PIPE_CHK_STOP_ON_FAIL_EN
  localparam int CONST_BUSY = 3, CONST_ERR = 1, LAT1_BUSY = 3, LAT1_ERR = 1, CORR_BUSY = 7;
`else
  localparam int CONST_BUSY = 10, CONST_ERR = 7, LAT1_BUSY = 10, LAT1_ERR = 8, CORR_BUSY = 10;
`endif

  always #5 clock = ~clock;

  // Stand-in pipelines: two flops is the matching DUT, one flop models a wrong latency.
  always @(posedge clock) begin
    d1    <= stim_out;
    d2    <= d1;
    d1_20 <= stim20;
    d2_20 <= d1_20;
  end

  always_comb begin
    case (mode)
      1:       resp_in = 4'h3;
      2:       resp_in = d1;
      3:       resp_in = (d2 == 4'h4) ? 4'hF : d2;
      default: resp_in = d2;
    endcase
  end

  assign resp20 = d2_20;

  pipe_seq_checker #(.WIDTH(4), .LATENCY(2), .CHECK_LEN(8)) u_dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .stim_out      (stim_out),
    .resp_in       (resp_in),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  pipe_seq_checker #(.WIDTH(4), .LATENCY(2), .CHECK_LEN(20)) u_dut20 (
    .clock         (clock),
    .reset         (reset),
    .start         (start20),
    .stim_out      (stim20),
    .resp_in       (resp20),
    .busy          (busy20),
    .done          (done20),
    .fail          (fail20),
    .err_count     (err20),
    .first_err_idx (idx20)
  );

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One full run: pulse start, follow the run to done, optionally re-pulse start mid-run.
  task automatic apply_stimulus(input int m, input int restart_at, output int busy_cycles);
    int n;
    mode = m;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    n = 0;
    busy_cycles = 0;
    while (!done && n < 100) begin
      if (busy) begin
        busy_cycles++;
        check_output("stim_seq", {28'd0, stim_out}, {28'd0, n[3:0]});
      end
      start = (n == restart_at);
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    if (n >= 100) check_output("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input int busy_cycles, input int exp_busy,
                              input logic exp_fail, input logic [7:0] exp_err, input logic [7:0] exp_idx);
    check_output({tag, "_busy_len"}, busy_cycles, exp_busy);
    check_output({tag, "_done"},     {31'd0, done}, 32'd1);
    check_output({tag, "_stim_idle"}, {28'd0, stim_out}, 32'd0);
    check_output({tag, "_fail"},     {31'd0, fail}, {31'd0, exp_fail});
    check_output({tag, "_err"},      {24'd0, err_count}, {24'd0, exp_err});
    check_output({tag, "_idx"},      {24'd0, first_err_idx}, {24'd0, exp_idx});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bc;
    int n;
    reset   = 1'b1;
    start   = 1'b0;
    start20 = 1'b0;
    mode    = 0;
    #12;
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_fail", {31'd0, fail}, 32'd0);
    check_output("rst_err",  {24'd0, err_count}, 32'd0);
    check_output("rst_idx",  {24'd0, first_err_idx}, 32'hFF);
    check_output("rst_stim", {28'd0, stim_out}, 32'd0);
    @(negedge clock) reset = 1'b0;

    $display("[TB] clean run, matching latency");
    apply_stimulus(0, -1, bc);
    check_result("clean", bc, 10, 1'b0, 8'd0, 8'hFF);

    $display("[TB] response stuck at 3");
    apply_stimulus(1, -1, bc);
    check_result("const3", bc, CONST_BUSY, 1'b1, 8'(CONST_ERR), 8'd0);

    $display("[TB] DUT with latency 1");
    apply_stimulus(2, -1, bc);
    check_result("lat1", bc, LAT1_BUSY, 1'b1, 8'(LAT1_ERR), 8'd0);

    $display("[TB] single corrupted sample j=4");
    apply_stimulus(3, -1, bc);
    check_result("corrupt4", bc, CORR_BUSY, 1'b1, 8'd1, 8'd4);

    $display("[TB] start re-pulsed during CHECK");
    apply_stimulus(0, 5, bc);
    check_result("restart", bc, 10, 1'b0, 8'd0, 8'hFF);

    $display("[TB] reset mid-run");
    mode = 1;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check_output("midrst_busy", {31'd0, busy}, 32'd0);
    check_output("midrst_stim", {28'd0, stim_out}, 32'd0);
    check_output("midrst_fail", {31'd0, fail}, 32'd0);
    check_output("midrst_done", {31'd0, done}, 32'd0);
    check_output("midrst_err",  {24'd0, err_count}, 32'd0);
    check_output("midrst_idx",  {24'd0, first_err_idx}, 32'hFF);
    #3 reset = 1'b0;
    apply_stimulus(0, -1, bc);
    check_result("post_rst", bc, 10, 1'b0, 8'd0, 8'hFF);

    $display("[TB] CHECK_LEN=20 wrap run");
    @(posedge clock); #1 start20 = 1'b1;
    @(posedge clock); #1 start20 = 1'b0;
    n  = 0;
    bc = 0;
    while (!done20 && n < 100) begin
      if (busy20) begin
        bc++;
        if (n == 15 || n == 16 || n == 21)
          check_output("wrap_stim", {28'd0, stim20}, {28'd0, n[3:0]});
      end
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) check_output("wrap_timeout", 32'd0, 32'd1);
    check_output("wrap_busy_len", bc, 22);
    check_output("wrap_fail", {31'd0, fail20}, 32'd0);
    check_output("wrap_err",  {24'd0, err20}, 32'd0);
    check_output("wrap_idx",  {24'd0, idx20}, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
